// File: rtl/vga_timing_gen_pkg.sv
// Shared raster types, default 640x480@60 timing and the sync/blank decode helper.
`default_nettype none

package vga_timing_gen_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    localparam vga_sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Bounds are int so a sync window ending exactly at 1024 still compares correctly.
    function automatic vga_sync_t sync_decode(
        input coord_t x,
        input coord_t y,
        input int     h_active,
        input int     hs_start,
        input int     hs_end,
        input int     v_active,
        input int     vs_start,
        input int     vs_end
    );
        vga_sync_t s;
        s.hs      = !((int'(x) >= hs_start) && (int'(x) < hs_end));
        s.vs      = !((int'(y) >= vs_start) && (int'(y) < vs_end));
        s.blank_n = (int'(x) < h_active) && (int'(y) < v_active);
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: pixel strobe, coordinates, DAC sync/blank and the frame tick.
`default_nettype none

interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic   pix_ce;
    coord_t DrawX;
    coord_t DrawY;
    logic   VGA_HS;
    logic   VGA_VS;
    logic   VGA_BLANK_N;
    logic   VGA_SYNC_N;
    logic   frame_clk;

    modport master (
        output pix_ce, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_clk
    );

    modport slave (
        input pix_ce, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_clk
    );

endinterface

`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay.sv
// Pixel-enabled shift register that retimes HS/VS/BLANK_N to match downstream RGB latency.
`default_nettype none

module vga_timing_gen_sync_delay
    import vga_timing_gen_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ce,
    input  vga_sync_t d,
    output vga_sync_t q
);

    generate
        if (DEPTH == 0) begin : g_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= SYNC_RESET;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_pipe
            vga_sync_t pipe [DEPTH];

            // Stages start out holding the idle triple so nothing visible leaks before the raster fills.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe[i] <= SYNC_RESET;
                    end
                    q <= SYNC_RESET;
                end else if (ce) begin
                    pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                    q <= pipe[DEPTH-1];
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, X/Y counters, sync/blank decode with retiming, frame tick.
`default_nettype none

module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_DLY = 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t     X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t     Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t     Y_VIS    = coord_t'(V_ACTIVE - 1);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
        if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be 1..4");
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 3) begin : g_bad_dly
            $error("vga_timing_gen: SYNC_DLY must be 0..3");
        end
    endgenerate

    logic [1:0] div;
    logic       pix_ce;
    coord_t     draw_x;
    coord_t     draw_y;
    coord_t     x_next;
    coord_t     y_next;
    logic       x_last;
    vga_sync_t  sync_next;
    vga_sync_t  sync_out;

    assign x_last = (draw_x == X_LAST);

    always_comb begin
        x_next = x_last ? '0 : draw_x + 10'd1;
        y_next = draw_y;
        if (x_last) begin
            y_next = (draw_y == Y_LAST) ? '0 : draw_y + 10'd1;
        end
    end

    // pix_ce is registered: it is high in the cycle after div reaches its last count,
    // which puts the first strobe on the CLK_DIV-th clock after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div    <= '0;
            pix_ce <= 1'b0;
            draw_x <= '0;
            draw_y <= '0;
        end else begin
            pix_ce <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? 2'd0 : div + 2'd1;
            if (pix_ce) begin
                draw_x <= x_next;
                draw_y <= y_next;
            end
        end
    end

    // Decoding the upcoming coordinates lets a zero-depth pipe land aligned with DrawX/DrawY.
    assign sync_next = sync_decode(x_next, y_next, H_ACTIVE, HS_START, HS_END,
                                   V_ACTIVE, VS_START, VS_END);

    vga_timing_gen_sync_delay #(
        .DEPTH (SYNC_DLY)
    ) u_sync_delay (
        .clk   (Clk),
        .rst_n (Reset_n),
        .ce    (pix_ce),
        .d     (sync_next),
        .q     (sync_out)
    );

    assign vga.pix_ce      = pix_ce;
    assign vga.DrawX       = draw_x;
    assign vga.DrawY       = draw_y;
    assign vga.VGA_HS      = sync_out.hs;
    assign vga.VGA_VS      = sync_out.vs;
    assign vga.VGA_BLANK_N = sync_out.blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    // Built only from registers, so it is a clean one-Clk pulse on the entering-vblank tick.
    assign vga.frame_clk   = pix_ce && x_last && (draw_y == Y_VIS);

endmodule

`default_nettype wire
